// File: rtl/switch_debouncer_if.sv
// Switch-side bundle for the two-channel debouncer: raw switches in,
// debounced levels, edge pulses and activity flag out.
interface switch_debouncer_if;
    logic sw0;
    logic sw1;
    logic sw0_db;
    logic sw1_db;
    logic sw0_rise;
    logic sw0_fall;
    logic sw1_rise;
    logic sw1_fall;
    logic busy;

    modport master (
        output sw0, sw1,
        input  sw0_db, sw1_db, sw0_rise, sw0_fall, sw1_rise, sw1_fall, busy
    );

    modport slave (
        input  sw0, sw1,
        output sw0_db, sw1_db, sw0_rise, sw0_fall, sw1_rise, sw1_fall, busy
    );
endinterface

// File: rtl/switch_debouncer.sv
// Two independent switch debouncers: 2-flop synchronizer, saturating run
// counter against the debounced level, registered level and edge pulses.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    switch_debouncer_if.slave sw_io
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sw_raw;
    logic [1:0] sync_w;
    logic [1:0] db_w;
    logic [1:0] rise_w;
    logic [1:0] fall_w;

    assign sw_raw = {sw_io.sw1, sw_io.sw0};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             meta_q;
        logic             sync_q;
        logic             db_q;
        logic             db_d;
        logic             rise_q;
        logic             fall_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Any cycle where the synchronized input agrees with the level
        // restarts the run; the counter therefore never passes CNT_TC.
        always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (sync_q != db_q) begin
                if (cnt_q == CNT_TC) begin
                    db_d = sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_q <= 1'b0;
                sync_q <= 1'b0;
                db_q   <= 1'b0;
                cnt_q  <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                meta_q <= sw_raw[g];
                sync_q <= meta_q;
                db_q   <= db_d;
                cnt_q  <= cnt_d;
                rise_q <= db_d & ~db_q;
                fall_q <= ~db_d & db_q;
            end
        end

        assign sync_w[g] = sync_q;
        assign db_w[g]   = db_q;
        assign rise_w[g] = rise_q;
        assign fall_w[g] = fall_q;
    end

    assign sw_io.sw0_db   = db_w[0];
    assign sw_io.sw1_db   = db_w[1];
    assign sw_io.sw0_rise = rise_w[0];
    assign sw_io.sw0_fall = fall_w[0];
    assign sw_io.sw1_rise = rise_w[1];
    assign sw_io.sw1_fall = fall_w[1];
    // Built purely from flops so it carries no path from the raw switches.
    assign sw_io.busy     = |(sync_w ^ db_w);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized bouncing phase, all compared every cycle to a window model.
module tb_switch_debouncer;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rise0_cnt = 0;
    int   fall0_cnt = 0;

    switch_debouncer_if swif ();

    switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_io (swif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: S is the switch seen two edges late; the level flips on an edge
    // when each of the last D synchronized samples disagreed with it.
    bit m_s1 [2];
    bit m_s  [2];
    bit m_db [2];
    bit m_rise [2];
    bit m_fall [2];
    bit hist [2][$];
    bit flip;
    bit sw_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s[c] = 0; m_db[c] = 0;
                m_rise[c] = 0; m_fall[c] = 0;
                hist[c].delete();
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                flip = (hist[c].size() >= D);
                for (int i = 0; i < hist[c].size(); i++)
                    if (hist[c][i] == m_db[c]) flip = 0;
                m_rise[c] = flip && !m_db[c];
                m_fall[c] = flip && m_db[c];
                if (flip) m_db[c] = !m_db[c];
                sw_now = (c == 0) ? swif.sw0 : swif.sw1;
                m_s[c]  = m_s1[c];
                m_s1[c] = sw_now;
                hist[c].push_back(m_s[c]);
                if (hist[c].size() > D) void'(hist[c].pop_front());
            end
        end
    end

    function automatic logic [6:0] dut_vec();
        return {swif.sw0_db, swif.sw1_db, swif.sw0_rise, swif.sw0_fall,
                swif.sw1_rise, swif.sw1_fall, swif.busy};
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_db[0], m_db[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1],
                (m_s[0] != m_db[0]) || (m_s[1] != m_db[1])};
    endfunction

    always @(negedge clk) begin
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%b required=%b (db0 db1 r0 f0 r1 f1 busy)",
                     $time, dut_vec(), model_vec());
        end
        if (swif.sw0_rise === 1'b1) rise0_cnt++;
        if (swif.sw0_fall === 1'b1) fall0_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    int  left [2];
    bit  bouncy [2];
    bit  val [2];

    initial begin
        rst_n = 1'b0;
        swif.sw0 = 1'b0;
        swif.sw1 = 1'b0;
        ticks(3);
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        ticks(2);

        // clean step on sw0
        swif.sw0 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            ticks(1);
            if (e == 1) check("step_busy_e1", 32'(swif.busy), 32'h0);
            if (e == 2) check("step_busy_e2", 32'(swif.busy), 32'h1);
            if (e == 5) check("step_db_e5", 32'({swif.sw0_db, swif.busy}), 32'h1);
            if (e == 6) check("step_e6", 32'({swif.sw0_db, swif.sw0_rise, swif.busy}), 32'h6);
            if (e == 7) check("step_e7", 32'({swif.sw0_db, swif.sw0_rise}), 32'h2);
        end

        // 3-cycle dip must not propagate
        fall0_cnt = 0;
        swif.sw0 = 1'b0;
        ticks(3);
        swif.sw0 = 1'b1;
        ticks(10);
        check("dip_db", 32'(swif.sw0_db), 32'h1);
        check("dip_busy", 32'(swif.busy), 32'h0);
        check("dip_no_fall", 32'(fall0_cnt), 32'h0);

        // toggling then final hold high
        swif.sw0 = 1'b0;
        ticks(10);
        check("toggle_pre_db", 32'(swif.sw0_db), 32'h0);
        rise0_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            swif.sw0 = (i % 2 == 0);
            ticks(1);
        end
        swif.sw0 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            ticks(1);
            if (e == 5) check("toggle_db_e5", 32'(swif.sw0_db), 32'h0);
            if (e == 6) check("toggle_db_e6", 32'(swif.sw0_db), 32'h1);
        end
        ticks(3);
        check("toggle_one_rise", 32'(rise0_cnt), 32'h1);

        // simultaneous step on both channels
        swif.sw0 = 1'b0;
        ticks(10);
        swif.sw0 = 1'b1;
        swif.sw1 = 1'b1;
        ticks(5);
        check("both_e5", 32'({swif.sw0_db, swif.sw1_db}), 32'h0);
        ticks(1);
        check("both_e6", 32'({swif.sw0_db, swif.sw1_db, swif.sw0_rise, swif.sw1_rise}), 32'hF);

        // reset in the middle of a count
        swif.sw0 = 1'b0;
        swif.sw1 = 1'b0;
        ticks(10);
        swif.sw0 = 1'b1;
        swif.sw1 = 1'b1;
        ticks(3);
        @(posedge clk);
        #1 check("midcount_busy", 32'(swif.busy), 32'h1);
        #1 rst_n = 1'b0;
        #1 check("midcount_reset_clear", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        ticks(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            ticks(1);
            if (e == 5) check("post_reset_e5", 32'({swif.sw1_db, swif.sw1_rise}), 32'h0);
            if (e == 6) check("post_reset_e6", 32'({swif.sw1_db, swif.sw1_rise}), 32'h3);
        end

        // randomized bouncing with occasional asynchronous resets
        for (int c = 0; c < 2; c++) begin
            left[c] = 0;
            val[c] = 1'b1;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (left[c] == 0) begin
                    bouncy[c] = 1'($urandom_range(0, 1));
                    left[c] = $urandom_range(1, 12);
                    if (!bouncy[c]) val[c] = 1'($urandom_range(0, 1));
                end
                left[c]--;
                if (bouncy[c]) val[c] = 1'($urandom_range(0, 1));
            end
            swif.sw0 = val[0];
            swif.sw1 = val[1];
            ticks(1);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_reset_clear", 32'(dut_vec()), 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive clock cycles a synchronized input must differ from its debounced level before that level changes (10 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 20, SHALL set the width of each debounce counter.
REQ-003 CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 SW0  input  1  SHALL be the raw, asynchronous, bouncing data switch.
REQ-006 SW1  input  1  SHALL be the raw, asynchronous, bouncing clock switch.
REQ-007 SW0_DB, SW1_DB  output  1 each  SHALL be the registered debounced levels, fed downstream as the flip-flop D and CLK.
REQ-008 SW0_RISE, SW0_FALL, SW1_RISE, SW1_FALL  output  1 each  SHALL be registered single-cycle pulses marking debounced-level transitions.
REQ-009 BUSY  output  1  SHALL be high while any channel's synchronized input differs from its debounced level.

Function
REQ-010 Each channel SHALL pass its switch through a two-flop synchronizer; the second flop output is the channel's sync value S.
REQ-011 Channels SHALL be fully independent; simultaneous activity on SW0 and SW1 SHALL be filtered in parallel with no interaction.
REQ-012 On an edge where S equals the debounced level, the channel counter SHALL clear to 0.
REQ-013 On an edge where S differs and counter equals DEBOUNCE_CYCLES-1, the debounced level SHALL take S and the counter SHALL clear to 0.
REQ-014 On an edge where S differs and counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 Any single cycle of S returning to the debounced level (bounce) SHALL restart the count from 0.
REQ-016 For a clean input step, the debounced level SHALL change on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new switch value as edge 1.
REQ-017 The RISE (FALL) pulse SHALL be high for exactly the one cycle following the edge on which the debounced level goes 0->1 (1->0), coincident with the new level.
REQ-018 RISE and FALL of the same channel SHALL never be high together.
REQ-019 BUSY SHALL be the combinational OR over channels of (S != debounced level), built from registered signals only.
REQ-020 Legal parameters: 1 <= DEBOUNCE_CYCLES <= 2^CNT_W; DEBOUNCE_CYCLES=1 SHALL give pure synchronization (level changes on edge 3).
REQ-021 Counters SHALL never wrap; the count saturates at DEBOUNCE_CYCLES-1 by construction of REQ-013.

Reset
REQ-022 RST_N low SHALL immediately clear synchronizer flops, counters, debounced levels, all pulse outputs, and BUSY to 0, regardless of CLK.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for the aborted transition.
REQ-024 After RST_N deasserts with a switch held high, that channel SHALL debounce to 1 per REQ-016 and emit its RISE pulse.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-025 SW0 0->1 clean step -> SW0_DB rises on edge 6, SW0_RISE high exactly one cycle, BUSY high from edge 2 to edge 6.
REQ-026 SW0 toggles 1,0,1,0 each cycle for 10 cycles then holds 1 -> no SW0_DB change until 6 edges after the final 0->1, one SW0_RISE.
REQ-027 SW0_DB=1, SW0 dips to 0 for 3 cycles -> SW0_DB stays 1, no FALL pulse, counter returns to 0.
REQ-028 SW0 and SW1 step 0->1 on the same cycle -> both _DB rise on edge 6 together with both RISE pulses.
REQ-029 RST_N pulsed low at edge 4 of a count -> all outputs 0 at once; with SW1 held 1, SW1_DB rises 6 edges after RST_N release.
